// File: rtl/nf10_cutter_axi_lite_regs_if.sv
// AXI4-Lite bus bundle between a control-plane master and the cutter register slave.
interface nf10_cutter_axi_lite_regs_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [DATA_W-1:0] S_AXI_WDATA;
  logic [STRB_W-1:0] S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [DATA_W-1:0] S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/nf10_cutter_axi_lite_regs.sv
// AXI4-Lite register slave for the packet cutter: cut configuration registers
// driven to the datapath plus a saturating, write-to-clear cut-packet counter.
module nf10_cutter_axi_lite_regs #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR = 32'h7780_0000,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR = 32'h7780_FFFF
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          reset,
  nf10_cutter_axi_lite_regs_if.slave    s_axi,
  output logic                          cut_en,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cut_words,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cut_offset,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cut_bytes,
  input  logic                          pkt_cut_pulse
);
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] IDX_EN     = 3'd0;
  localparam logic [2:0] IDX_WORDS  = 3'd1;
  localparam logic [2:0] IDX_OFFSET = 3'd2;
  localparam logic [2:0] IDX_BYTES  = 3'd3;
  localparam logic [2:0] IDX_COUNT  = 3'd4;

  // Map covers offsets 0x00..0x13; address bits [1:0] never matter.
  function automatic logic dec_hit(input logic [AW-1:0] addr);
    logic [AW-1:0] off;
    off = addr - C_BASEADDR;
    dec_hit = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR) && (off < AW'(20));
  endfunction

  function automatic logic [2:0] dec_idx(input logic [AW-1:0] addr);
    logic [AW-1:0] off;
    off = addr - C_BASEADDR;
    dec_idx = 3'(off >> 2);
  endfunction

  function automatic logic [DW-1:0] reg_sel(input logic [2:0] idx, input logic en,
                                            input logic [DW-1:0] words, offset, bytes, count);
    case (idx)
      IDX_EN:     reg_sel = DW'(en);
      IDX_WORDS:  reg_sel = words;
      IDX_OFFSET: reg_sel = offset;
      IDX_BYTES:  reg_sel = bytes;
      IDX_COUNT:  reg_sel = count;
      default:    reg_sel = '0;
    endcase
  endfunction

  logic          aw_latched, w_latched, ar_pending;
  logic [AW-1:0] aw_addr_q, ar_addr_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  logic          bvalid, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;
  logic [DW-1:0] pkt_cut_count;

  logic          aw_hs_c, w_hs_c, ar_hs_c, wr_commit_c, rd_issue_c;
  logic          wr_hit_c, rd_hit_c, count_clr_c;
  logic [2:0]    wr_idx_c, rd_idx_c;
  logic [DW-1:0] wr_old_c, wr_new_c, rd_val_c;

  assign s_axi.S_AXI_AWREADY = !aw_latched && !bvalid;
  assign s_axi.S_AXI_WREADY  = !w_latched && !bvalid;
  assign s_axi.S_AXI_ARREADY = !rvalid;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RRESP   = rresp;
  assign s_axi.S_AXI_RDATA   = rdata;

  always_comb begin
    aw_hs_c     = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    w_hs_c      = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
    ar_hs_c     = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    wr_commit_c = aw_latched && w_latched;
    rd_issue_c  = ar_pending && !rvalid;
    wr_hit_c    = dec_hit(aw_addr_q);
    wr_idx_c    = dec_idx(aw_addr_q);
    rd_hit_c    = dec_hit(ar_addr_q);
    rd_idx_c    = dec_idx(ar_addr_q);
    wr_old_c    = reg_sel(wr_idx_c, cut_en, cut_words, cut_offset, cut_bytes, pkt_cut_count);
    rd_val_c    = reg_sel(rd_idx_c, cut_en, cut_words, cut_offset, cut_bytes, pkt_cut_count);
    wr_new_c    = wr_old_c;
    for (int i = 0; i < int'(SW); i++) begin
      if (w_strb_q[i]) wr_new_c[8*i +: 8] = w_data_q[8*i +: 8];
    end
    count_clr_c = wr_commit_c && wr_hit_c && (wr_idx_c == IDX_COUNT) && (|w_strb_q);
  end

  // Bus channels: address/data latch one cycle, then respond.
  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) begin
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
      ar_pending <= 1'b0;
      aw_addr_q  <= '0;
      ar_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
      rvalid     <= 1'b0;
      rresp      <= RESP_OKAY;
      rdata      <= '0;
    end else begin
      if (aw_hs_c) begin
        aw_latched <= 1'b1;
        aw_addr_q  <= s_axi.S_AXI_AWADDR;
      end
      if (w_hs_c) begin
        w_latched <= 1'b1;
        w_data_q  <= s_axi.S_AXI_WDATA;
        w_strb_q  <= s_axi.S_AXI_WSTRB;
      end
      if (wr_commit_c) begin
        aw_latched <= 1'b0;
        w_latched  <= 1'b0;
        bvalid     <= 1'b1;
        bresp      <= wr_hit_c ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid && s_axi.S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
      if (ar_hs_c) begin
        ar_pending <= 1'b1;
        ar_addr_q  <= s_axi.S_AXI_ARADDR;
      end else if (rd_issue_c) begin
        ar_pending <= 1'b0;
      end
      if (rd_issue_c) begin
        rvalid <= 1'b1;
        rdata  <= rd_hit_c ? rd_val_c : '0;
        rresp  <= rd_hit_c ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid && s_axi.S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) begin
      cut_en     <= 1'b0;
      cut_words  <= '0;
      cut_offset <= '0;
      cut_bytes  <= '0;
    end else if (wr_commit_c && wr_hit_c) begin
      case (wr_idx_c)
        IDX_EN:     cut_en     <= wr_new_c[0];
        IDX_WORDS:  cut_words  <= wr_new_c;
        IDX_OFFSET: cut_offset <= wr_new_c;
        IDX_BYTES:  cut_bytes  <= wr_new_c;
        default: ;
      endcase
    end
  end

  // A clearing write beats a coincident pulse.
  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) begin
      pkt_cut_count <= '0;
    end else if (count_clr_c) begin
      pkt_cut_count <= '0;
    end else if (pkt_cut_pulse && (pkt_cut_count != '1)) begin
      pkt_cut_count <= pkt_cut_count + DW'(1);
    end
  end
endmodule

// File: doc/nf10_cutter_axi_lite_regs.md
Name: nf10_cutter_axi_lite_regs

Overview:
AXI4-Lite register responder (slave) for the packet cutter's control plane. It terminates the register write and read transactions that a bus master or testbench issues at the cutter's address window. It holds the cut configuration (enable, start word, byte offset mask, byte count) and drives those values to the cutter datapath. It also counts cut packets from a datapath pulse and exposes the count as a readable, clearable status register.

Parameters:
C_S_AXI_ADDR_WIDTH, 32, AXI-Lite address width
C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width (fixed 32; other values unsupported)
C_BASEADDR, 32'h77800000, base of register window
C_HIGHADDR, 32'h7780FFFF, top of register window (inclusive)

Ports:
S_AXI_ACLK  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  32  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  write byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  32  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
cut_en  out  1  cut enable, CUT_EN[0]
cut_words  out  32  first word to cut
cut_offset  out  32  last-word byte mask
cut_bytes  out  32  bytes kept
pkt_cut_pulse  in  1  one-cycle pulse per packet cut

Behaviour:
- Clock and reset: S_AXI_ACLK is the only clock. reset is synchronous and active-high.
- Register map (offset = addr - C_BASEADDR, word aligned):
  - 0x00 CUT_EN: RW, bit0 only; upper bits read 0.
  - 0x04 CUT_WORDS: RW.
  - 0x08 CUT_OFFSET: RW.
  - 0x0C CUT_BYTES: RW.
  - 0x10 PKT_CUT_COUNT: RO; any write to it clears it to 0.
- Reset values:
  - all config registers 0; PKT_CUT_COUNT 0.
  - BVALID, RVALID 0; BRESP, RRESP, RDATA 0.
  - AWREADY, WREADY, ARREADY 1 in the cycle after reset deasserts.
  - All pending or latched transactions are discarded. Reset mid-transaction aborts with no response issued.
- Write channel:
  - AW and W are accepted independently, each into its own latch.
  - AWREADY = !aw_latched && !BVALID; WREADY = !w_latched && !BVALID.
  - Once both are latched, or both handshake in the same cycle at edge N: at edge N+1 the register updates, BVALID=1, and both latches clear.
  - BVALID holds, with BRESP stable, until BREADY=1 at an edge. New AW/W are not accepted while BVALID=1.
  - WSTRB[i] gates byte i; WSTRB=0 is legal, performs no write, and returns OKAY.
- Read channel:
  - ARREADY = !RVALID.
  - A handshake at edge N gives RVALID=1 with RDATA/RRESP at edge N+1.
  - RVALID holds, with data stable, until RREADY=1. ARREADY returns to 1 on the same edge RVALID drops.
- Decode errors:
  - address outside [C_BASEADDR, C_HIGHADDR], or offset not in the map, gives RESP=2'b10 (SLVERR).
  - such a write has no effect; such a read returns RDATA=0.
  - AWADDR/ARADDR[1:0] are ignored.
- Read/write overlap: read and write channels run concurrently. A read of a register written at the same edge returns the old value.
- Outputs: cut_en, cut_words, cut_offset and cut_bytes are driven directly from the registers, with 0 added cycles after the write edge.
- PKT_CUT_COUNT:
  - +1 on each cycle with pkt_cut_pulse=1; saturates at 32'hFFFFFFFF.
  - A clear-write and a pulse at the same edge: the clear wins and the count becomes 0 (that pulse is dropped).

Test Plan:
- Reset release → AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, cut_* all 0, read 0x10 returns 0 with OKAY.
- Configuration sequence: writes 0x77800004←0, 0x77800008←FFFFFFFE, 0x7780000C←3F, 0x77800000←1, each with AW+W in the same cycle and BREADY=1 → BVALID one cycle after each handshake, BRESP=00; cut_words=0, cut_offset=FFFFFFFE, cut_bytes=3F, cut_en=1; readback of each returns the same values (0x00 reads 1).
- AW presented 3 cycles before W, with BREADY low for 4 cycles after BVALID → AWREADY low while latched, BVALID held with BRESP stable, next AW accepted only after the B handshake; register updates exactly once.
- WSTRB=4'b0010 with WDATA=AABBCCDD to 0x0C holding 3F → reads back 0000CC3F.
- Read 0x77800014 and write 0x77810000 → RRESP=BRESP=10, RDATA=0, all registers unchanged.
- 5 pulses on pkt_cut_pulse → 0x10 reads 5; write 0x10 coincident with a pulse → reads 0; reset asserted while RVALID=1 with RREADY=0 → RVALID drops, no stale response afterwards.
